// File: rtl/dma_cmd_ctrl.sv
// DMA command controller: software register front-end that issues one DMA command
// and reports BUSY/DONE/ERR status. Define DMA_PERF_CNT_EN to build the latency counter on RO[2].
module dma_cmd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int RW_REG_NUM = 48,
  parameter int RO_REG_NUM = 16,
  parameter int LEN_WIDTH  = 23
) (
  input  logic                                   s_axi_aclk,
  input  logic                                   s_axi_areset,
  input  logic [RW_REG_NUM-1:0][DATA_WIDTH-1:0]  RW_axilite_regs,
  output logic [RO_REG_NUM-1:0][DATA_WIDTH-1:0]  RO_axilite_regs,
  output logic                                   cmd_valid,
  input  logic                                   cmd_ready,
  output logic [DATA_WIDTH-1:0]                  cmd_src,
  output logic [DATA_WIDTH-1:0]                  cmd_dst,
  output logic [LEN_WIDTH-1:0]                   cmd_len,
  input  logic                                   done_valid,
  input  logic                                   done_err,
  output logic                                   irq
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t                 state;
  logic                   start_p0, clr_p0, irq_en_p0;
  logic                   start_p1, clr_p1;
  logic                   start_ev, clr_ev;
  logic [LEN_WIDTH-1:0]   len_p0;
  logic                   len_ok;
  logic                   busy, done, err;
  logic [31:0]            comp_cnt;
  logic                   unused_rw;

  // Stage 0: software control bits and edge detection against registered copies
  assign start_p0  = RW_axilite_regs[0][0];
  assign irq_en_p0 = RW_axilite_regs[0][1];
  assign clr_p0    = RW_axilite_regs[0][2];
  assign len_p0    = RW_axilite_regs[3][LEN_WIDTH-1:0];
  assign start_ev  = start_p0 & ~start_p1;
  assign clr_ev    = clr_p0 & ~clr_p1;
  assign len_ok    = (len_p0 != '0) && (len_p0[1:0] == 2'b00);
  assign busy      = (state != IDLE);
  assign unused_rw = ^RW_axilite_regs;

  // Stage 1: command FSM, status flags and interrupt
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state     <= IDLE;
      start_p1  <= 1'b0;
      clr_p1    <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_src   <= '0;
      cmd_dst   <= '0;
      cmd_len   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      comp_cnt  <= '0;
      irq       <= 1'b0;
    end else begin
      start_p1 <= start_p0;
      clr_p1   <= clr_p0;
      irq      <= irq_en_p0 & (done | err);
      // CLR applies in any state; state-specific updates below take precedence
      if (clr_ev) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_ev) begin
            if (len_ok) begin
              cmd_src   <= RW_axilite_regs[1];
              cmd_dst   <= RW_axilite_regs[2];
              cmd_len   <= len_p0;
              cmd_valid <= 1'b1;
              done      <= 1'b0;
              err       <= 1'b0;
              state     <= ISSUE;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (done_valid) begin
            err   <= done_err;
            state <= FINISH;
          end
        end
        FINISH: begin
          done     <= 1'b1;
          comp_cnt <= comp_cnt + 32'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMA_PERF_CNT_EN
  logic [DATA_WIDTH-1:0] perf_run, perf_lat;

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage 1: cycles from entering ISSUE up to the edge that enters FINISH
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      perf_run <= '0;
      perf_lat <= '0;
    end else begin
      if (state == IDLE && start_ev && len_ok)
        perf_run <= '0;
      else if (state == ISSUE || state == WAIT)
        perf_run <= sat_inc(perf_run);
      if (state == FINISH)
        perf_lat <= perf_run;
    end
  end
`endif

  // Stage 2: status word assembly
  always_comb begin
    RO_axilite_regs       = '0;
    RO_axilite_regs[0][0] = busy;
    RO_axilite_regs[0][1] = done;
    RO_axilite_regs[0][2] = err;
    RO_axilite_regs[1]    = DATA_WIDTH'(comp_cnt);
`ifdef DMA_PERF_CNT_EN
    RO_axilite_regs[2]    = perf_lat;
`endif
  end

endmodule

// File: tb/tb_dma_cmd_ctrl.sv
// Directed table-driven bench for dma_cmd_ctrl plus hand sequences for
// async reset mid-transfer, payload stability and the latency counter.
module tb_dma_cmd_ctrl;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [47:0][31:0]    rw;
  logic [15:0][31:0]    ro;
  logic                 cmd_valid, cmd_ready;
  logic [31:0]          cmd_src, cmd_dst;
  logic [22:0]          cmd_len;
  logic                 done_valid, done_err, irq;

  int n_vec = 0;
  int n_bad = 0;

  dma_cmd_ctrl dut (
    .s_axi_aclk      (clk),
    .s_axi_areset    (rst),
    .RW_axilite_regs (rw),
    .RO_axilite_regs (ro),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_src         (cmd_src),
    .cmd_dst         (cmd_dst),
    .cmd_len         (cmd_len),
    .done_valid      (done_valid),
    .done_err        (done_err),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctl;
    logic [22:0] len;
    logic        rdy, dv, de;
    logic        ev;
    logic [2:0]  est;
    logic [31:0] ecnt;
    logic        eirq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] ctl, input logic [22:0] len,
                     input logic rdy, input logic dv, input logic de,
                     input logic ev, input logic [2:0] est,
                     input logic [31:0] ecnt, input logic eirq);
    vec_t v;
    v.ctl = ctl; v.len = len; v.rdy = rdy; v.dv = dv; v.de = de;
    v.ev = ev; v.est = est; v.ecnt = ecnt; v.eirq = eirq;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic [2:0] ctl);
    rw[0] = {29'd0, ctl};
  endtask

  initial begin
    rst        = 1'b1;
    rw         = '0;
    cmd_ready  = 1'b0;
    done_valid = 1'b0;
    done_err   = 1'b0;

    //    ctl     len      rdy   dv    de    | ev    st      cnt    irq
    add(3'b000, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 32'd0, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 32'd0, 1'b0);
    add(3'b001, 23'd64, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'd0, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'd0, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'd0, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'd1, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'd1, 1'b0);
    add(3'b000, 23'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'd1, 1'b0);
    add(3'b001, 23'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 32'd1, 1'b0);
    add(3'b100, 23'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd1, 1'b0);
    add(3'b000, 23'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd1, 1'b0);
    add(3'b001, 23'd6,  1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 32'd1, 1'b0);
    add(3'b010, 23'd6,  1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 32'd1, 1'b1);
    add(3'b011, 23'd64, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 32'd1, 1'b1);
    add(3'b011, 23'd64, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'd1, 1'b0);
    add(3'b011, 23'd64, 1'b0, 1'b1, 1'b1, 1'b0, 3'b101, 32'd1, 1'b0);
    add(3'b011, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 32'd2, 1'b1);
    add(3'b011, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 32'd2, 1'b1);
    add(3'b110, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd2, 1'b1);
    add(3'b110, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd2, 1'b0);
    add(3'b010, 23'd64, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 32'd2, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 32'd2, 1'b0);
    add(3'b000, 23'd64, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'd2, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'd2, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'd2, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'd3, 1'b0);
    add(3'b001, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'd3, 1'b0);
    add(3'b000, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'd3, 1'b0);
    add(3'b101, 23'd64, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 32'd3, 1'b0);
    add(3'b101, 23'd64, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'd3, 1'b0);
    add(3'b101, 23'd64, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'd3, 1'b0);
    add(3'b101, 23'd64, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'd4, 1'b0);

    // reset state
    step;
    step;
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_ro_all", 64'(|ro), 64'd0);
    check("rst_cmd_payload", 64'(|{cmd_src, cmd_dst, cmd_len}), 64'd0);
    rst   = 1'b0;
    rw[1] = 32'h0000_1000;
    rw[2] = 32'h0000_2000;

    foreach (tbl[i]) begin
      set_ctl(tbl[i].ctl);
      rw[3]      = {9'd0, tbl[i].len};
      cmd_ready  = tbl[i].rdy;
      done_valid = tbl[i].dv;
      done_err   = tbl[i].de;
      step;
      check($sformatf("row%0d_status", i),
            64'({cmd_valid, ro[0][2:0], irq}),
            64'({tbl[i].ev, tbl[i].est, tbl[i].eirq}));
      check($sformatf("row%0d_count", i), 64'(ro[1]), 64'(tbl[i].ecnt));
      if (tbl[i].ev)
        check($sformatf("row%0d_payload", i),
              {cmd_src, cmd_dst}, {32'h0000_1000, 32'h0000_2000});
    end
    cmd_ready  = 1'b0;
    done_valid = 1'b0;
    done_err   = 1'b0;
    check("ro_unused_word", 64'(ro[5]), 64'd0);

    // payload stability and async reset while waiting for completion
    set_ctl(3'b000);
    step;
    set_ctl(3'b001);
    step;
    check("seq_issue_valid", 64'(cmd_valid), 64'd1);
    rw[1]     = 32'hDEAD_0000;
    rw[3]     = 23'd128;
    cmd_ready = 1'b1;
    #2;
    check("seq_payload_stable", {cmd_src, 9'd0, cmd_len},
          {32'h0000_1000, 9'd0, 23'd64});
    step;
    cmd_ready = 1'b0;
    check("seq_wait_valid_low", 64'(cmd_valid), 64'd0);
    check("seq_hold_after_hs", 64'(cmd_src), 64'h1000);
    step;
    step;
    step;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("async_rst_ro_all", 64'(|ro), 64'd0);
    check("async_rst_payload", 64'(|{cmd_src, cmd_dst, cmd_len}), 64'd0);
    rw[1] = 32'h0000_1000;
    rw[3] = 23'd64;
    set_ctl(3'b000);
    step;
    rst = 1'b0;
    step;

    // restart after reset; done_valid 10 cycles after the handshake
    set_ctl(3'b001);
    step;
    check("post_rst_issue", 64'({cmd_valid, cmd_len}), 64'({1'b1, 23'd64}));
    cmd_ready = 1'b1;
    step;
    cmd_ready = 1'b0;
    check("post_rst_hs", 64'(cmd_valid), 64'd0);
    repeat (9) step;
    done_valid = 1'b1;
    step;
    done_valid = 1'b0;
    check("post_rst_finish", 64'(ro[0]), 64'b001);
    step;
    check("post_rst_done", 64'(ro[0]), 64'b010);
    check("post_rst_count", 64'(ro[1]), 64'd1);
`ifdef DMA_PERF_CNT_EN
    check("perf_count", 64'(ro[2]), 64'd11);
`else
    check("perf_absent", 64'(ro[2]), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
